// File: rtl/step_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// step_ctrl_pkg - shared types and defaults for the step/run controller
// Rev 1.0
// ------------------------------------------------------------------
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } dbc_state_e;

  localparam int DEBOUNCE_MS_DEF = 20;
  localparam int CNT_W_DEF       = 16;
  localparam int ARM_CYCLES      = 3;

endpackage
`default_nettype wire

// File: rtl/step_ctrl_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_toggle_det - 2-FF synchronizer plus toggle-to-tick detector
// Rev 1.0
// ------------------------------------------------------------------
module sync_toggle_det (
  input  logic clk_100mhz,
  input  logic rst,
  input  logic din,
  input  logic arm,
  output logic sync_out,
  output logic tick
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;
  logic dly_d, dly_q;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  // Either edge of the divider level is one tick.
  assign sync_out = sync_q;
  assign tick     = arm & (sync_q ^ dly_q);

endmodule
`default_nettype wire

// File: rtl/step_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// step_ctrl - CPU enable strobe from 1 s ticks (run) or debounced presses (step)
// Rev 1.0
// ------------------------------------------------------------------
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk_100mhz,
  input  logic             rst,
  input  logic             clk_1msec_in,
  input  logic             clk_1sec_in,
  input  logic             btn_step,
  input  logic             sw_run,
  output logic             cpu_en,
  output logic             btn_clean,
  output logic [CNT_W-1:0] step_count
);

  localparam logic [7:0] DEB_LIM = 8'(DEBOUNCE_MS);

  logic s_ms, s_sec, s_btn, s_run;
  logic ms_tick, sec_tick;
  logic btn_tick_unused, run_tick_unused;

  logic [1:0] arm_cnt_d, arm_cnt_q;
  logic       armed;

  dbc_state_e state_d, state_q;
  logic [7:0] dbc_cnt_d, dbc_cnt_q;
  logic       btn_clean_d, btn_clean_q;
  logic       press_evt;

  logic             cpu_en_d, cpu_en_q;
  logic [CNT_W-1:0] step_count_d, step_count_q;

  sync_toggle_det u_ms (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .din        (clk_1msec_in),
    .arm        (armed),
    .sync_out   (s_ms),
    .tick       (ms_tick)
  );

  sync_toggle_det u_sec (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .din        (clk_1sec_in),
    .arm        (armed),
    .sync_out   (s_sec),
    .tick       (sec_tick)
  );

  sync_toggle_det u_btn (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .din        (btn_step),
    .arm        (1'b0),
    .sync_out   (s_btn),
    .tick       (btn_tick_unused)
  );

  sync_toggle_det u_run (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .din        (sw_run),
    .arm        (1'b0),
    .sync_out   (s_run),
    .tick       (run_tick_unused)
  );

  // Ticks stay masked until the synchronizer pipeline has filled after reset.
  assign armed = (arm_cnt_q == 2'(ARM_CYCLES));

  always_comb begin
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 2'd1;
  end

  always_comb begin
    state_d     = state_q;
    dbc_cnt_d   = dbc_cnt_q;
    btn_clean_d = btn_clean_q;
    press_evt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_btn) begin
          state_d   = PRESS_WAIT;
          dbc_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s_btn) begin
          state_d   = IDLE;
          dbc_cnt_d = '0;
        end else if (ms_tick) begin
          if (dbc_cnt_q + 8'd1 == DEB_LIM) begin
            state_d     = PRESSED;
            dbc_cnt_d   = '0;
            btn_clean_d = 1'b1;
            press_evt   = 1'b1;
          end else begin
            dbc_cnt_d = dbc_cnt_q + 8'd1;
          end
        end
      end
      PRESSED: begin
        if (!s_btn) begin
          state_d   = RELEASE_WAIT;
          dbc_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s_btn) begin
          state_d   = PRESSED;
          dbc_cnt_d = '0;
        end else if (ms_tick) begin
          if (dbc_cnt_q + 8'd1 == DEB_LIM) begin
            state_d     = IDLE;
            dbc_cnt_d   = '0;
            btn_clean_d = 1'b0;
          end else begin
            dbc_cnt_d = dbc_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        dbc_cnt_d = '0;
      end
    endcase
  end

  // A single select means coincident sec_tick and press_evt cannot both fire.
  always_comb begin
    cpu_en_d     = s_run ? sec_tick : press_evt;
    step_count_d = cpu_en_q ? step_count_q + CNT_W'(1) : step_count_q;
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      arm_cnt_q    <= 2'd0;
      state_q      <= IDLE;
      dbc_cnt_q    <= 8'd0;
      btn_clean_q  <= 1'b0;
      cpu_en_q     <= 1'b0;
      step_count_q <= '0;
    end else begin
      arm_cnt_q    <= arm_cnt_d;
      state_q      <= state_d;
      dbc_cnt_q    <= dbc_cnt_d;
      btn_clean_q  <= btn_clean_d;
      cpu_en_q     <= cpu_en_d;
      step_count_q <= step_count_d;
    end
  end

  assign cpu_en     = cpu_en_q;
  assign btn_clean  = btn_clean_q;
  assign step_count = step_count_q;

endmodule
`default_nettype wire

// File: tb/tb_step_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_step_ctrl - self-checking bench for step_ctrl
// Rev 1.0
// ------------------------------------------------------------------
module tb_step_ctrl;

  localparam int DEB = 4;

  logic        clk_100mhz = 1'b0;
  logic        rst, clk_1msec_in, clk_1sec_in, btn_step, sw_run;
  logic        cpu_en, btn_clean, cpu_en_w, btn_clean_w;
  logic [15:0] step_count;
  logic [3:0]  step_count_w;

  int checks = 0;
  int errors = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  step_ctrl #(.DEBOUNCE_MS(DEB), .CNT_W(16)) dut (
    .clk_100mhz   (clk_100mhz),
    .rst          (rst),
    .clk_1msec_in (clk_1msec_in),
    .clk_1sec_in  (clk_1sec_in),
    .btn_step     (btn_step),
    .sw_run       (sw_run),
    .cpu_en       (cpu_en),
    .btn_clean    (btn_clean),
    .step_count   (step_count)
  );

  // Narrow counter copy so wrap-around is reachable in a short run.
  step_ctrl #(.DEBOUNCE_MS(DEB), .CNT_W(4)) dut_w (
    .clk_100mhz   (clk_100mhz),
    .rst          (rst),
    .clk_1msec_in (clk_1msec_in),
    .clk_1sec_in  (clk_1sec_in),
    .btn_step     (btn_step),
    .sw_run       (sw_run),
    .cpu_en       (cpu_en_w),
    .btn_clean    (btn_clean_w),
    .step_count   (step_count_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: inputs reach the logic two samples late, a level change is
  // one tick, and a button level is accepted after DEB ticks of disagreement.
  int          n;
  logic [2:0]  h_ms, h_sec, h_btn, h_run;
  logic        m_clean, m_was, m_cpu_en;
  int          m_cnt;
  logic [15:0] m_step;

  task automatic model_reset();
    n = 0;
    h_ms = '0; h_sec = '0; h_btn = '0; h_run = '0;
    m_clean = 1'b0; m_was = 1'b0; m_cpu_en = 1'b0; m_cnt = 0; m_step = '0;
  endtask

  task automatic model_step();
    logic ms_t, sec_t, b, r, evt, differ;
    if (rst) begin
      model_reset();
      return;
    end
    n++;
    ms_t  = (n >= 4) && (h_ms[1] != h_ms[2]);
    sec_t = (n >= 4) && (h_sec[1] != h_sec[2]);
    b     = h_btn[1];
    r     = h_run[1];
    evt   = 1'b0;
    differ = (b != m_clean);
    if (!differ) begin
      m_cnt = 0;
    end else if (m_was && ms_t) begin
      m_cnt++;
      if (m_cnt == DEB) begin
        m_clean = ~m_clean;
        m_cnt   = 0;
        evt     = m_clean;
        differ  = 1'b0;
      end
    end
    m_was    = differ;
    m_step   = m_step + {15'd0, m_cpu_en};
    m_cpu_en = r ? sec_t : evt;
    h_ms  = {h_ms[1:0],  clk_1msec_in};
    h_sec = {h_sec[1:0], clk_1sec_in};
    h_btn = {h_btn[1:0], btn_step};
    h_run = {h_run[1:0], sw_run};
  endtask

  int cyc_n;
  bit ms_run_en;
  int ms_half, ms_cnt;
  bit ms_tog;

  task automatic cyc();
    @(posedge clk_100mhz);
    model_step();
    @(negedge clk_100mhz);
    cyc_n++;
    chk("cpu_en", cpu_en, m_cpu_en);
    chk("btn_clean", btn_clean, m_clean);
    chk("step_count", step_count, m_step);
    chk("cpu_en_w", cpu_en_w, m_cpu_en);
    chk("btn_clean_w", btn_clean_w, m_clean);
    chk("step_count_w", step_count_w, m_step[3:0]);
    ms_tog = 1'b0;
    if (ms_run_en) begin
      ms_cnt++;
      if (ms_cnt >= ms_half) begin
        ms_cnt = 0;
        clk_1msec_in = ~clk_1msec_in;
        ms_tog = 1'b1;
      end
    end
  endtask

  task automatic run_cycles(input int k, output int pulses);
    pulses = 0;
    for (int i = 0; i < k; i++) begin
      cyc();
      pulses += int'(cpu_en);
    end
  endtask

  // Holds the button and reports pulses, last pulse cycle and the cycle of the
  // DEB-th ms toggle made while held (optionally toggling 1 s alongside it).
  task automatic press_track(input bit with_sec, output int np, output int tp, output int t4);
    int  cnt;
    logic prev_clean;
    cnt = 0; np = 0; tp = -1; t4 = -1;
    for (int i = 0; i < 300; i++) begin
      prev_clean = btn_clean;
      cyc();
      if (cpu_en === 1'b1) begin
        np++;
        tp = cyc_n;
        chk("press_clean_rise", {30'd0, prev_clean, btn_clean}, 32'd1);
      end
      if (ms_tog) begin
        cnt++;
        if (cnt == DEB) begin
          t4 = cyc_n;
          if (with_sec) clk_1sec_in = ~clk_1sec_in;
        end
      end
    end
  endtask

  typedef struct {
    logic run;
    int   toggles;
    int   exp_pulses;
  } vec_t;

  vec_t        tbl[4];
  int          p, tot, np, tp, t4, k;
  logic [15:0] s0, d16;
  logic [1:0]  st;

  initial begin
    tbl[0] = '{1'b1, 3, 3};
    tbl[1] = '{1'b0, 4, 0};
    tbl[2] = '{1'b1, 1, 1};
    tbl[3] = '{1'b0, 2, 0};

    rst = 1'b1; clk_1sec_in = 1'b1; clk_1msec_in = 1'b1; btn_step = 1'b0; sw_run = 1'b1;
    ms_run_en = 1'b0; ms_half = 50; ms_cnt = 0; ms_tog = 1'b0; cyc_n = 0;
    model_reset();

    // Inputs already high at reset release must not produce a tick.
    repeat (5) cyc();
    rst = 1'b0;
    run_cycles(100, p);
    chk("arm_no_pulse", p, 0);
    chk("arm_step", step_count, 0);

    // Run mode: each 1 s toggle gives one pulse, three cycles later.
    for (int i = 0; i < 5; i++) begin
      clk_1sec_in = ~clk_1sec_in;
      for (int c = 1; c <= 6; c++) begin
        cyc();
        chk("sec_latency", cpu_en, (c == 3) ? 32'd1 : 32'd0);
      end
      run_cycles(994, p);
    end
    chk("sec_step5", step_count, 5);

    for (int i = 0; i < 4; i++) begin
      sw_run = tbl[i].run;
      run_cycles(6, p);
      s0 = step_count;
      tot = 0;
      for (int t = 0; t < tbl[i].toggles; t++) begin
        clk_1sec_in = ~clk_1sec_in;
        run_cycles(8, p);
        tot += p;
      end
      d16 = step_count - s0;
      chk($sformatf("tbl%0d_pulses", i), tot, tbl[i].exp_pulses);
      chk($sformatf("tbl%0d_step", i), d16, tbl[i].exp_pulses);
    end

    // Step mode: bouncing button, then a clean hold.
    sw_run = 1'b0; ms_half = 50; ms_run_en = 1'b1;
    run_cycles(10, p);
    tot = 0;
    for (int s = 0; s < 10; s++) begin
      btn_step = (s % 2 == 0);
      run_cycles(20, p);
      tot += p;
    end
    chk("bounce_no_pulse", tot, 0);
    chk("bounce_clean", btn_clean, 0);
    btn_step = 1'b1;
    press_track(1'b0, np, tp, t4);
    chk("press_one_pulse", np, 1);
    chk("press_latency", tp, t4 + 3);
    run_cycles(1000, p);
    chk("hold_no_repeat", p, 0);
    chk("hold_clean", btn_clean, 1);

    // Short release glitch is rejected.
    btn_step = 1'b0;
    run_cycles(110, p);
    tot = p;
    st = dut.state_q;
    chk("glitch_release_wait", st, 3);
    btn_step = 1'b1;
    run_cycles(30, p);
    tot += p;
    st = dut.state_q;
    chk("glitch_no_pulse", tot, 0);
    chk("glitch_clean", btn_clean, 1);
    chk("glitch_state", st, 2);

    // Press accepted in the same cycle as a 1 s tick while running.
    btn_step = 1'b0;
    run_cycles(300, p);
    chk("release_clean", btn_clean, 0);
    sw_run = 1'b1;
    run_cycles(5, p);
    s0 = step_count;
    btn_step = 1'b1;
    press_track(1'b1, np, tp, t4);
    d16 = step_count - s0;
    chk("coinc_one_pulse", np, 1);
    chk("coinc_latency", tp, t4 + 3);
    chk("coinc_step", d16, 1);
    chk("coinc_clean", btn_clean, 1);

    // Drive the narrow counter to all-ones, then across the wrap.
    k = int'(4'hF - m_step[3:0]);
    for (int i = 0; i < k; i++) begin
      clk_1sec_in = ~clk_1sec_in;
      run_cycles(6, p);
    end
    chk("w_allones", step_count_w, 15);
    clk_1sec_in = ~clk_1sec_in;
    run_cycles(6, p);
    chk("w_wrap", step_count_w, 0);

    // Asynchronous reset while waiting out a press.
    sw_run = 1'b0; btn_step = 1'b0;
    run_cycles(300, p);
    chk("pre_rst_clean", btn_clean, 0);
    btn_step = 1'b1;
    run_cycles(30, p);
    st = dut.state_q;
    chk("rst_in_press_wait", st, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_clean", btn_clean, 0);
    chk("rst_step", step_count, 0);
    chk("rst_step_w", step_count_w, 0);
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    st = dut.state_q;
    chk("rst_state_idle", st, 0);
    run_cycles(300, p);

    // Randomized traffic against the model.
    ms_half = 3;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) btn_step = ~btn_step;
      if ($urandom_range(199) == 0) sw_run = ~sw_run;
      if ($urandom_range(9) == 0) clk_1sec_in = ~clk_1sec_in;
      if ($urandom_range(499) == 0) ms_half = $urandom_range(2, 8);
      if ($urandom_range(1499) == 0) begin
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
